// File: rtl/lru_grant_sequencer.sv
// LRU arbiter that sequences one shared resource through grant, acknowledge and
// completion, holding the grant for the whole transaction and aborting stuck ones.
module lru_grant_sequencer #(
    parameter int NUMCLIENTS = 4,
    parameter int IDW        = $clog2(NUMCLIENTS),
    parameter int MAXHOLD    = 16,
    parameter int HCW        = $clog2(MAXHOLD + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NUMCLIENTS-1:0] req,
    input  logic                  res_ack,
    input  logic                  res_done,
    output logic [NUMCLIENTS-1:0] gnt,
    output logic                  gnt_valid,
    output logic [IDW-1:0]        gnt_id,
    output logic                  res_start,
    output logic                  abort,
    output logic [1:0]            state_dbg
);

    // Handshake: gnt is held from res_start until done, withdrawal or abort;
    // res_ack counts only while the grant is in GRANT, res_done only after ack.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [IDW-1:0]  age [NUMCLIENTS];
    logic [HCW-1:0]  hold_cnt;

    logic            win_found;
    logic [IDW-1:0]  win_id;
    logic [IDW-1:0]  win_age;
    logic [IDW-1:0]  cur_age;
    logic            load_gnt;
    logic            clr_gnt;
    logic            age_upd;
    logic            timeout;

    // Ages are a permutation, so the oldest requester is always unique.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_age   = '0;
        for (int i = 0; i < NUMCLIENTS; i++) begin
            if (req[i] && (!win_found || age[i] > win_age)) begin
                win_found = 1'b1;
                win_id    = IDW'(i);
                win_age   = age[i];
            end
        end
    end

    assign cur_age = age[gnt_id];

    always_comb begin
        state_nxt = state;
        load_gnt  = 1'b0;
        clr_gnt   = 1'b0;
        age_upd   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    load_gnt  = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (res_ack) begin
                    age_upd = 1'b1;
                    if (res_done) begin
                        clr_gnt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = BUSY;
                    end
                end else if (!req[gnt_id]) begin
                    clr_gnt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (res_done) begin
                    clr_gnt   = 1'b1;
                    state_nxt = IDLE;
                end else if (hold_cnt >= HCW'(MAXHOLD - 1)) begin
                    timeout   = 1'b1;
                    clr_gnt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                clr_gnt   = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_id    <= '0;
            res_start <= 1'b0;
            abort     <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            res_start <= load_gnt;
            abort     <= timeout;
            if (load_gnt) begin
                gnt    <= NUMCLIENTS'(1) << win_id;
                gnt_id <= win_id;
            end else if (clr_gnt) begin
                gnt    <= '0;
                gnt_id <= '0;
            end
            if (state == GRANT) begin
                hold_cnt <= '0;
            end else if (state == BUSY && hold_cnt < HCW'(MAXHOLD - 1)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    // Winner becomes youngest; everyone younger than it ages by one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUMCLIENTS; i++) begin
                age[i] <= IDW'(NUMCLIENTS - 1 - i);
            end
        end else if (age_upd) begin
            for (int j = 0; j < NUMCLIENTS; j++) begin
                if (IDW'(j) == gnt_id) begin
                    age[j] <= '0;
                end else if (age[j] < cur_age) begin
                    age[j] <= age[j] + 1'b1;
                end
            end
        end
    end

    assign gnt_valid = |gnt;
    assign state_dbg = state;

endmodule
